// File: rtl/edge_pkg.sv
// Shared types for the multi-channel edge detector.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int MAX_CHANNELS = 16;

endpackage

// File: rtl/sync_chain.sv
// Per-line metastability synchroniser; STAGES=0 degenerates to a plain wire.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_wire
      logic w_unused_clk;
      assign w_unused_clk = clk ^ nrst;
      assign q = d;
    end else begin : g_ff
      logic [STAGES-1:0] r_sh;
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          r_sh <= '0;
        end else begin
          r_sh[0] <= d;
          for (int k = 1; k < STAGES; k++) begin
            r_sh[k] <= r_sh[k-1];
          end
        end
      end
      assign q = r_sh[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/edge_event_latch.sv
// Multi-channel edge detector with sticky pending/overflow flags and a
// lowest-index-first pending channel report for interrupt sequencing.
module edge_event_latch #(
  parameter int                  CHANNELS    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] HIST_RST    = '0,
  localparam int                 ID_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enableFFs,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   ack,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   pending,
  output logic [CHANNELS-1:0]   overflow,
  output logic                  any_pending,
  output logic [ID_W-1:0]       pend_id
);

  import edge_pkg::*;

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic       w_s;
      logic       w_rise;
      logic       w_fall;
      logic       w_pulse;
      edge_mode_t w_mode;
      logic       r_hist;
      logic       r_pend;
      logic       r_ovf;

      sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (in[g]),
        .q    (w_s)
      );

      assign w_mode = edge_mode_t'(mode[2*g +: 2]);
      assign w_rise = w_s & ~r_hist;
      assign w_fall = ~w_s & r_hist;

      always_comb begin
        w_pulse = 1'b0;
        case (w_mode)
          EDGE_RISE: w_pulse = w_rise;
          EDGE_FALL: w_pulse = w_fall;
          EDGE_BOTH: w_pulse = w_rise | w_fall;
          default:   w_pulse = 1'b0;
        endcase
        w_pulse = w_pulse & enableFFs;
      end

      // History freezes with enableFFs so a transition across a frozen
      // window is still seen once advancing resumes.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          r_hist <= HIST_RST[g];
        end else if (enableFFs) begin
          r_hist <= w_s;
        end
      end

      // A new edge beats a simultaneous ack so no event is dropped.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          r_pend <= 1'b0;
          r_ovf  <= 1'b0;
        end else if (enableFFs) begin
          if (w_pulse) begin
            r_pend <= 1'b1;
            if (r_pend && !ack[g]) begin
              r_ovf <= 1'b1;
            end else if (ack[g]) begin
              r_ovf <= 1'b0;
            end
          end else if (ack[g]) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
      end

      assign edge_pulse[g] = w_pulse;
      assign pending[g]    = r_pend;
      assign overflow[g]   = r_ovf;
    end
  endgenerate

  assign any_pending = |pending;

  always_comb begin
    pend_id = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pend_id = ID_W'(i);
      end
    end
  end

endmodule
